lynx_tap_loader: RTL and testbench

LYNX_TAP_LOADER -- requirements
Module: lynx_tap_loader

---
 rtl/lynx_tap_pkg.sv | 50 +++++
 rtl/tap_mem_writer.sv | 38 +++
 rtl/lynx_tap_loader.sv | 189 ++++++++++++++++++
 tb/tb_lynx_tap_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_tap_pkg.sv
// Shared definitions for the Lynx TAP loader: parser states, TAP marker/type codes
// and the default BASIC load/exec addresses.
`timescale 1ns/1ps
package lynx_tap_pkg;

    typedef enum logic [3:0] {
        ST_SYNC    = 4'd0,
        ST_NAME    = 4'd1,
        ST_TYPE    = 4'd2,
        ST_LEN_LO  = 4'd3,
        ST_LEN_HI  = 4'd4,
        ST_LOAD_LO = 4'd5,
        ST_LOAD_HI = 4'd6,
        ST_PAYLOAD = 4'd7,
        ST_CHECK   = 4'd8,
        ST_EXEC_LO = 4'd9,
        ST_EXEC_HI = 4'd10,
        ST_DONE    = 4'd11,
        ST_ERR     = 4'd12
    } tap_state_t;

    localparam logic [7:0] TAP_QUOTE  = 8'h22;
    localparam logic [7:0] TAP_LEAD   = 8'hA5;
    localparam logic [7:0] TAP_TYPE_B = 8'h42;
    localparam logic [7:0] TAP_TYPE_M = 8'h4D;
    localparam logic [7:0] TAP_TYPE_D = 8'h44;
    localparam logic [7:0] TAP_TYPE_A = 8'h41;

    localparam logic [15:0] DEF_BASIC_LOAD = 16'h694D;
    localparam logic [15:0] DEF_BASIC_EXEC = 16'h6800;

    function automatic logic is_known_type(input logic [7:0] t);
        return (t == TAP_TYPE_B) || (t == TAP_TYPE_M) ||
               (t == TAP_TYPE_D) || (t == TAP_TYPE_A);
    endfunction

    function automatic logic has_load_field(input logic [7:0] t);
        return (t == TAP_TYPE_M) || (t == TAP_TYPE_D);
    endfunction

    function automatic logic has_exec_field(input logic [7:0] t);
        return (t == TAP_TYPE_M);
    endfunction

    // BASIC blocks carry no check byte, so their payload ends the block.
    function automatic tap_state_t state_after_payload(input logic [7:0] t);
        return (t == TAP_TYPE_B) ? ST_DONE : ST_CHECK;
    endfunction

endpackage

// File: rtl/tap_mem_writer.sv
// Single-outstanding memory write port: latches one payload byte and holds the
// request until the memory accepts it, stalling the downloader meanwhile.
`timescale 1ns/1ps
module tap_mem_writer
    import lynx_tap_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    output logic              ioctl_wait
);

    // A new request can only arrive while idle, because the stall blocks new bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
        end else if (wr_req) begin
            mem_wr   <= 1'b1;
            mem_addr <= wr_addr;
            mem_dout <= wr_data;
        end else if (mem_wr && mem_ready) begin
            mem_wr   <= 1'b0;
        end
    end

    assign ioctl_wait = mem_wr;

endmodule

// File: rtl/lynx_tap_loader.sv
// Camputers Lynx TAP parser: walks block headers, streams payload bytes to memory
// and reports block completion, start vectors and checksum/format errors.
`timescale 1ns/1ps
module lynx_tap_loader
    import lynx_tap_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter logic [15:0] BASIC_LOAD = DEF_BASIC_LOAD,
    parameter logic [15:0] BASIC_EXEC = DEF_BASIC_EXEC,
    parameter int          CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic              autostart_basic,
    output logic [ADDR_W-1:0] exec_addr,
    output logic              exec_valid,
    output logic [7:0]        file_type,
    output logic [CNT_W-1:0]  block_count,
    output logic              chk_err,
    output logic              fmt_err
);

    tap_state_t        state, state_next;
    logic              dl_q, dl_rise, dl_fall, trunc_pend;
    logic              accept, byte_ok, abort_req, abort_now, done_fire, wr_req;
    logic              last_payload;
    logic [7:0]        len_lo, load_lo, exec_lo, sum;
    logic [15:0]       len, idx;
    logic [ADDR_W-1:0] load_addr, exec_field, wr_addr;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // A truncated download parks the parser until the in-flight write drains.
    always_comb begin
        state_next = state;
        if (abort_now) begin
            state_next = ST_SYNC;
        end else if (abort_req) begin
            state_next = state;
        end else if (state == ST_DONE) begin
            if (!mem_wr) begin
                state_next = (byte_ok && ioctl_dout == TAP_QUOTE) ? ST_NAME : ST_SYNC;
            end
        end else if (byte_ok) begin
            case (state)
                ST_SYNC:    if (ioctl_dout == TAP_QUOTE) state_next = ST_NAME;
                ST_NAME:    if (ioctl_dout == TAP_QUOTE) state_next = ST_TYPE;
                ST_TYPE: begin
                    if (ioctl_dout == TAP_LEAD)          state_next = ST_TYPE;
                    else if (is_known_type(ioctl_dout))  state_next = ST_LEN_LO;
                    else                                 state_next = ST_ERR;
                end
                ST_LEN_LO:  state_next = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (has_load_field(file_type))        state_next = ST_LOAD_LO;
                    else if ({ioctl_dout, len_lo} == 16'd0) state_next = state_after_payload(file_type);
                    else                                 state_next = ST_PAYLOAD;
                end
                ST_LOAD_LO: state_next = ST_LOAD_HI;
                ST_LOAD_HI: state_next = (len == 16'd0) ? state_after_payload(file_type) : ST_PAYLOAD;
                ST_PAYLOAD: if (last_payload) state_next = state_after_payload(file_type);
                ST_CHECK:   state_next = has_exec_field(file_type) ? ST_EXEC_LO : ST_DONE;
                ST_EXEC_LO: state_next = ST_EXEC_HI;
                ST_EXEC_HI: state_next = ST_DONE;
                ST_ERR:     state_next = ST_ERR;
                default:    state_next = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        accept       = ioctl_download & ioctl_wr & ~ioctl_wait;
        abort_req    = trunc_pend |
                       (dl_fall & (state != ST_SYNC) & (state != ST_DONE));
        abort_now    = abort_req & ~mem_wr;
        byte_ok      = accept & ~abort_req;
        done_fire    = (state == ST_DONE) & ~mem_wr & ~abort_req;
        wr_req       = byte_ok & (state == ST_PAYLOAD);
        wr_addr      = load_addr + ADDR_W'(idx);
        last_payload = (idx == len - 16'd1);
    end

    // Rise-clear sits after block completion so a new download always starts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= 1'b0;
            trunc_pend  <= 1'b0;
            exec_valid  <= 1'b0;
            exec_addr   <= '0;
            exec_field  <= '0;
            file_type   <= '0;
            block_count <= '0;
            chk_err     <= 1'b0;
            fmt_err     <= 1'b0;
            len_lo      <= '0;
            load_lo     <= '0;
            exec_lo     <= '0;
            sum         <= '0;
            len         <= '0;
            idx         <= '0;
            load_addr   <= '0;
        end else begin
            dl_q       <= ioctl_download;
            exec_valid <= 1'b0;

            if (abort_req) trunc_pend <= ~abort_now;
            if (abort_now) fmt_err <= 1'b1;

            if (done_fire) begin
                if (block_count != '1) block_count <= block_count + 1'b1;
                if (has_exec_field(file_type)) begin
                    exec_valid <= 1'b1;
                    exec_addr  <= exec_field;
                end else if (file_type == TAP_TYPE_B && autostart_basic) begin
                    exec_valid <= 1'b1;
                    exec_addr  <= ADDR_W'(BASIC_EXEC);
                end
            end

            if (dl_rise) begin
                chk_err     <= 1'b0;
                fmt_err     <= 1'b0;
                block_count <= '0;
            end

            if (byte_ok) begin
                case (state)
                    ST_TYPE: begin
                        if (is_known_type(ioctl_dout)) begin
                            file_type <= ioctl_dout;
                            sum       <= '0;
                            idx       <= '0;
                        end else if (ioctl_dout != TAP_LEAD) begin
                            fmt_err   <= 1'b1;
                        end
                    end
                    ST_LEN_LO:  len_lo <= ioctl_dout;
                    ST_LEN_HI: begin
                        len <= {ioctl_dout, len_lo};
                        if (!has_load_field(file_type)) load_addr <= ADDR_W'(BASIC_LOAD);
                    end
                    ST_LOAD_LO: load_lo   <= ioctl_dout;
                    ST_LOAD_HI: load_addr <= ADDR_W'({ioctl_dout, load_lo});
                    ST_PAYLOAD: begin
                        sum <= sum + ioctl_dout;
                        idx <= idx + 16'd1;
                    end
                    ST_CHECK:   if (ioctl_dout != sum) chk_err <= 1'b1;
                    ST_EXEC_LO: exec_lo    <= ioctl_dout;
                    ST_EXEC_HI: exec_field <= ADDR_W'({ioctl_dout, exec_lo});
                    default: ;
                endcase
            end
        end
    end

    tap_mem_writer #(
        .ADDR_W (ADDR_W)
    ) u_writer (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (ioctl_dout),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_wr     (mem_wr),
        .ioctl_wait (ioctl_wait)
    );

endmodule

// File: tb/tb_lynx_tap_loader.sv
// Directed bench for lynx_tap_loader: feeds hand-built TAP blocks and compares
// memory writes, start pulses and status flags against hand-computed values.
`timescale 1ns/1ps
module tb_lynx_tap_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        mem_ready = 1'b1;
    logic        autostart_basic = 1'b1;
    logic [15:0] exec_addr;
    logic        exec_valid;
    logic [7:0]  file_type;
    logic [3:0]  block_count;
    logic        chk_err;
    logic        fmt_err;

    int checks = 0;
    int errors = 0;
    int exec_cnt = 0;
    int wr_base;
    int ex_base;
    logic [15:0] wa_log[$];
    logic [7:0]  wd_log[$];
    logic [7:0]  payload[0:7];

    lynx_tap_loader dut (
        .clk             (clk),
        .reset           (reset),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_dout      (ioctl_dout),
        .ioctl_wait      (ioctl_wait),
        .mem_addr        (mem_addr),
        .mem_dout        (mem_dout),
        .mem_wr          (mem_wr),
        .mem_ready       (mem_ready),
        .autostart_basic (autostart_basic),
        .exec_addr       (exec_addr),
        .exec_valid      (exec_valid),
        .file_type       (file_type),
        .block_count     (block_count),
        .chk_err         (chk_err),
        .fmt_err         (fmt_err)
    );

    always #5 clk = ~clk;

    // Memory side: a write completes at the posedge following a negedge with wr & ready.
    always @(negedge clk) begin
        if (mem_wr && mem_ready) begin
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_dout);
        end
        if (exec_valid) exec_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (ioctl_wait && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (ioctl_wait) checkOutput("wait_timeout", 32'd1, 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(posedge clk);
        #1 ioctl_wr = 1'b0;
    endtask

    task automatic sendHeader(input logic [7:0] t, input logic [15:0] n, input logic [15:0] load);
        applyStimulus(8'hA5);
        applyStimulus(8'h22);
        applyStimulus(8'h4E);
        applyStimulus(8'h22);
        applyStimulus(8'hA5);
        applyStimulus(t);
        applyStimulus(n[7:0]);
        applyStimulus(n[15:8]);
        if (t == 8'h4D || t == 8'h44) begin
            applyStimulus(load[7:0]);
            applyStimulus(load[15:8]);
        end
    endtask

    task automatic sendBlock(input logic [7:0] t, input logic [15:0] load, input int n,
                             input logic [7:0] chk, input logic [15:0] ex);
        sendHeader(t, n[15:0], load);
        for (int i = 0; i < n; i++) applyStimulus(payload[i]);
        if (t != 8'h42) applyStimulus(chk);
        if (t == 8'h4D) begin
            applyStimulus(ex[7:0]);
            applyStimulus(ex[15:8]);
        end
        idle(6);
    endtask

    task automatic checkWrite(input string tag, input int k, input logic [15:0] a, input logic [7:0] d);
        if (k < wa_log.size()) begin
            checkOutput({tag, "_addr"}, {16'd0, wa_log[k]}, {16'd0, a});
            checkOutput({tag, "_data"}, {24'd0, wd_log[k]}, {24'd0, d});
        end else begin
            checkOutput({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_wr"},     {31'd0, mem_wr},      32'd0);
        checkOutput({tag, "_wait"},       {31'd0, ioctl_wait},  32'd0);
        checkOutput({tag, "_exec_valid"}, {31'd0, exec_valid},  32'd0);
        checkOutput({tag, "_chk_err"},    {31'd0, chk_err},     32'd0);
        checkOutput({tag, "_fmt_err"},    {31'd0, fmt_err},     32'd0);
        checkOutput({tag, "_blk_cnt"},    {28'd0, block_count}, 32'd0);
        checkOutput({tag, "_mem_addr"},   {16'd0, mem_addr},    32'd0);
        checkOutput({tag, "_mem_dout"},   {24'd0, mem_dout},    32'd0);
        checkOutput({tag, "_exec_addr"},  {16'd0, exec_addr},   32'd0);
        checkOutput({tag, "_file_type"},  {24'd0, file_type},   32'd0);
    endtask

    task automatic markBase();
        wr_base = wa_log.size();
        ex_base = exec_cnt;
    endtask

    task automatic restartDownload();
        ioctl_download = 1'b0;
        idle(3);
        ioctl_download = 1'b1;
        idle(3);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle(3);
        checkAllZero("reset");
        @(posedge clk); #1 reset = 1'b0;
        ioctl_download = 1'b1;
        idle(3);

        $display("[TB] BASIC block with autostart");
        markBase();
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        sendBlock(8'h42, 16'h0000, 3, 8'h00, 16'h0000);
        checkOutput("b_nwr", wa_log.size() - wr_base, 3);
        checkWrite("b_w0", wr_base,     16'h694D, 8'h11);
        checkWrite("b_w1", wr_base + 1, 16'h694E, 8'h22);
        checkWrite("b_w2", wr_base + 2, 16'h694F, 8'h33);
        checkOutput("b_exec_cnt", exec_cnt - ex_base, 1);
        checkOutput("b_exec_addr", {16'd0, exec_addr}, 32'h6800);
        checkOutput("b_blk_cnt", {28'd0, block_count}, 1);
        checkOutput("b_type", {24'd0, file_type}, 32'h42);

        $display("[TB] machine-code block following in the same download");
        markBase();
        payload[0] = 8'hAA; payload[1] = 8'h55;
        sendBlock(8'h4D, 16'hC000, 2, 8'hFF, 16'hC000);
        checkOutput("m_nwr", wa_log.size() - wr_base, 2);
        checkWrite("m_w0", wr_base,     16'hC000, 8'hAA);
        checkWrite("m_w1", wr_base + 1, 16'hC001, 8'h55);
        checkOutput("m_chk_err", {31'd0, chk_err}, 0);
        checkOutput("m_exec_addr", {16'd0, exec_addr}, 32'hC000);
        checkOutput("m_exec_cnt", exec_cnt - ex_base, 1);
        checkOutput("bm_blk_cnt", {28'd0, block_count}, 2);
        checkOutput("bm_exec_total", exec_cnt, 2);

        $display("[TB] data block with bad check byte");
        markBase();
        payload[0] = 8'h01; payload[1] = 8'h02;
        sendBlock(8'h44, 16'h2000, 2, 8'h00, 16'h0000);
        checkWrite("d_w0", wr_base,     16'h2000, 8'h01);
        checkWrite("d_w1", wr_base + 1, 16'h2001, 8'h02);
        checkOutput("d_chk_err", {31'd0, chk_err}, 1);
        checkOutput("d_exec_cnt", exec_cnt - ex_base, 0);
        checkOutput("d_blk_cnt", {28'd0, block_count}, 3);
        checkOutput("d_exec_hold", {16'd0, exec_addr}, 32'hC000);

        $display("[TB] stalled memory on first write");
        restartDownload();
        checkOutput("rise_chk_clr", {31'd0, chk_err}, 0);
        checkOutput("rise_cnt_clr", {28'd0, block_count}, 0);
        autostart_basic = 1'b0;
        @(posedge clk); #1 mem_ready = 1'b0;
        markBase();
        sendHeader(8'h42, 16'd2, 16'h0000);
        applyStimulus(8'h5A);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_wait", {31'd0, ioctl_wait}, 1);
            checkOutput("stall_addr", {16'd0, mem_addr}, 32'h694D);
            checkOutput("stall_data", {24'd0, mem_dout}, 32'h5A);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        applyStimulus(8'hA6);
        idle(6);
        checkOutput("s_nwr", wa_log.size() - wr_base, 2);
        checkWrite("s_w0", wr_base,     16'h694D, 8'h5A);
        checkWrite("s_w1", wr_base + 1, 16'h694E, 8'hA6);
        checkOutput("s_exec_cnt", exec_cnt - ex_base, 0);
        checkOutput("s_blk_cnt", {28'd0, block_count}, 1);

        $display("[TB] bad type byte and truncated header");
        markBase();
        applyStimulus(8'h22); applyStimulus(8'h4E); applyStimulus(8'h22); applyStimulus(8'h5A);
        applyStimulus(8'h01); applyStimulus(8'h02);
        idle(3);
        checkOutput("z_fmt_err", {31'd0, fmt_err}, 1);
        checkOutput("z_nwr", wa_log.size() - wr_base, 0);
        checkOutput("z_type_hold", {24'd0, file_type}, 32'h42);
        checkOutput("z_blk_cnt", {28'd0, block_count}, 1);
        restartDownload();
        checkOutput("z_fmt_clr", {31'd0, fmt_err}, 0);
        applyStimulus(8'h22); applyStimulus(8'h4E); applyStimulus(8'h22);
        applyStimulus(8'h42); applyStimulus(8'h03);
        idle(2);
        ioctl_download = 1'b0;
        idle(3);
        checkOutput("trunc_fmt_err", {31'd0, fmt_err}, 1);
        ioctl_download = 1'b1;
        idle(3);

        $display("[TB] reset in the middle of a payload");
        markBase();
        payload[0] = 8'h7E;
        sendBlock(8'h4D, 16'h3000, 1, 8'h7E, 16'h1234);
        checkWrite("pre_w0", wr_base, 16'h3000, 8'h7E);
        checkOutput("pre_exec_addr", {16'd0, exec_addr}, 32'h1234);
        checkOutput("pre_blk_cnt", {28'd0, block_count}, 1);
        @(posedge clk); #1 mem_ready = 1'b0;
        sendHeader(8'h42, 16'd3, 16'h0000);
        applyStimulus(8'h11);
        @(negedge clk);
        checkOutput("mid_mem_wr", {31'd0, mem_wr}, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkAllZero("midrst");
        @(posedge clk); #1 reset = 1'b0;
        mem_ready = 1'b1;
        autostart_basic = 1'b1;
        idle(3);
        markBase();
        payload[0] = 8'hC3; payload[1] = 8'h3C;
        sendBlock(8'h42, 16'h0000, 2, 8'h00, 16'h0000);
        checkOutput("post_nwr", wa_log.size() - wr_base, 2);
        checkWrite("post_w0", wr_base,     16'h694D, 8'hC3);
        checkWrite("post_w1", wr_base + 1, 16'h694E, 8'h3C);
        checkOutput("post_exec_cnt", exec_cnt - ex_base, 1);
        checkOutput("post_exec_addr", {16'd0, exec_addr}, 32'h6800);
        checkOutput("post_blk_cnt", {28'd0, block_count}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
